// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I constants and decode helpers for the fetch slice.
// Provides the default datapath width, major opcode constants and the
// B-type immediate extractor used by static branch prediction.
package rv_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef logic [6:0] opcode_t;

   localparam opcode_t OPC_LOAD   = 7'b0000011;
   localparam opcode_t OPC_OP_IMM = 7'b0010011;
   localparam opcode_t OPC_AUIPC  = 7'b0010111;
   localparam opcode_t OPC_STORE  = 7'b0100011;
   localparam opcode_t OPC_OP     = 7'b0110011;
   localparam opcode_t OPC_LUI    = 7'b0110111;
   localparam opcode_t OPC_BRANCH = 7'b1100011;
   localparam opcode_t OPC_JALR   = 7'b1100111;
   localparam opcode_t OPC_JAL    = 7'b1101111;

   // Reassemble the scattered B-type immediate into a sign-extended byte offset.
   function automatic logic [31:0] bImm(input logic [31:0] ir);
      return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   endfunction

   // A conditional branch whose immediate sign bit is set jumps backwards.
   function automatic logic isBackwardBranch(input logic [31:0] ir);
      return (ir[6:0] == OPC_BRANCH) && ir[31];
   endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// rv_fetch_fifo: small synchronous FIFO used as the fetch prefetch queue.
// DEPTH must be a power of two so the pointers wrap naturally. A clear
// request empties the queue and wins over a push or pop in the same cycle.
module rv_fetch_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wrPtr_q, wrPtr_d;
   logic [PW-1:0]    rdPtr_q, rdPtr_d;
   logic [PW:0]      count_q, count_d;
   logic             doPush, doPop;

   assign full_o  = (count_q == (PW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rdPtr_q];

   // A pop is only honoured when something is stored; a push into a full
   // queue is only honoured when the head leaves in the same cycle.
   assign doPop  = pop_i && !empty_o;
   assign doPush = push_i && (!full_o || doPop);

   // Next pointer and occupancy values, with clear taking precedence.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (clear_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (doPush) begin
            wrPtr_d = wrPtr_q + PW'(1);
         end
         if (doPop) begin
            rdPtr_d = rdPtr_q + PW'(1);
         end
         case ({doPush, doPop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers return to empty on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the occupancy count says which slots are live.
   always_ff @(posedge clk) begin
      if (doPush && !clear_i) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

endmodule

// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: RV32I instruction-fetch stage.
// Owns the PC, issues one word read per cycle to a synchronous instruction
// memory while queue credit allows, buffers the returned words in a prefetch
// queue and hands them to decode with a valid/ready handshake. A redirect
// from execute flushes the queue and drops the read still in flight.
// Build option FETCH_BTFN_EN: static backward-taken branch prediction.
module rv_fetch_unit
   import rv_pkg::*;
#(
   parameter int              XLEN       = XLEN_DEFAULT,
   parameter int              IMEM_DEPTH = 1024,
   parameter int              FQ_DEPTH   = 4,
   parameter logic [XLEN-1:0] RESET_PC   = '0
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          halt_i,
   input  logic                          redirect_valid_i,
   input  logic [XLEN-1:0]               redirect_pc_i,
   output logic                          imem_req_o,
   output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr_o,
   input  logic [31:0]                   imem_rdata_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [31:0]                   out_ir_o,
   output logic [XLEN-1:0]               out_pc_o,
   output logic [XLEN-1:0]               out_npc_o,
   output logic                          out_pred_taken_o
);

   localparam int AW = $clog2(IMEM_DEPTH);
   localparam int CW = $clog2(FQ_DEPTH) + 1;
   localparam int EW = 1 + XLEN + 32;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] reqPc_q, reqPc_d;
   logic            inflight_q, inflight_d;
   logic [XLEN-1:0] seqPc, redirTarget;
   logic [CW:0]     occupancy;
   logic [CW-1:0]   fifoCount;
   logic            fifoFull, fifoEmpty;
   logic            issue, push, pop, predTake;
   logic [EW-1:0]   pushEntry, headEntry;
   logic [31:0]     headIr;
   logic [XLEN-1:0] headPc;
   logic            headPred;
   logic            unusedRedirLowBits;

   assign unusedRedirLowBits = ^redirect_pc_i[1:0];

   assign seqPc       = pc_q + XLEN'(4);
   assign redirTarget = {redirect_pc_i[XLEN-1:2], 2'b00};

   // Queue slots already taken plus the one promised to the read in flight;
   // a pop in this cycle deliberately gives no credit until the next one.
   assign occupancy = {1'b0, fifoCount} + {{CW{1'b0}}, inflight_q};

   assign issue = !rst && !halt_i && !redirect_valid_i && !fifoFull
                  && (occupancy < (CW+1)'(FQ_DEPTH));

   assign imem_req_o  = issue;
   assign imem_addr_o = pc_q[AW+1:2];

   assign pop = out_valid_o && out_ready_i;

`ifdef FETCH_BTFN_EN
   logic            discard_q, discard_d;
   logic [XLEN-1:0] predTarget;

   // The sequential word requested alongside a predicted branch is on the
   // wrong path, so its response is dropped instead of pushed.
   assign push       = inflight_q && !redirect_valid_i && !discard_q;
   assign predTake   = push && isBackwardBranch(imem_rdata_i);
   assign predTarget = reqPc_q + XLEN'($signed(bImm(imem_rdata_i)));
   assign discard_d  = predTake && issue;

   // Remember that the next returning word belongs to the abandoned path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         discard_q <= 1'b0;
      end else begin
         discard_q <= discard_d;
      end
   end
`else
   assign push     = inflight_q && !redirect_valid_i;
   assign predTake = 1'b0;
`endif

   assign pushEntry = {predTake, reqPc_q, imem_rdata_i};

   // Next PC: sequential on issue, then a predicted target, and a redirect
   // from execute overrides everything else.
   always_comb begin
      pc_d = pc_q;
      if (issue) begin
         pc_d = seqPc;
      end
`ifdef FETCH_BTFN_EN
      if (predTake) begin
         pc_d = predTarget;
      end
`endif
      if (redirect_valid_i) begin
         pc_d = redirTarget;
      end
   end

   // Track the address of the outstanding read so its response can be
   // tagged; issue already excludes redirect, so a redirect clears inflight.
   always_comb begin
      reqPc_d    = reqPc_q;
      inflight_d = issue;
      if (issue) begin
         reqPc_d = pc_q;
      end
   end

   // PC and outstanding-read state, restarting at RESET_PC on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         reqPc_q    <= '0;
         inflight_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         reqPc_q    <= reqPc_d;
         inflight_q <= inflight_d;
      end
   end

   rv_fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (FQ_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear_i (redirect_valid_i),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (pushEntry),
      .data_o  (headEntry),
      .count_o (fifoCount),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

   assign headIr   = headEntry[31:0];
   assign headPc   = headEntry[XLEN+31:32];
   assign headPred = headEntry[EW-1];

   // Decode only sees head fields while the head is valid; otherwise zeros,
   // which also gives clean outputs straight out of reset.
   always_comb begin
      out_valid_o      = !fifoEmpty;
      out_ir_o         = '0;
      out_pc_o         = '0;
      out_npc_o        = '0;
      out_pred_taken_o = 1'b0;
      if (!fifoEmpty) begin
         out_ir_o         = headIr;
         out_pc_o         = headPc;
         out_npc_o        = headPc + XLEN'(4);
         out_pred_taken_o = headPred;
      end
   end

endmodule

// File: tb/tb_rv_fetch_unit.sv
// tb_rv_fetch_unit: directed, table-driven bench for rv_fetch_unit with
// FQ_DEPTH=4, RESET_PC=0 and memory word k = 32'h0000_0013 | k<<20.
// Build option FETCH_BTFN_EN switches the expected branch behaviour.
module tb_rv_fetch_unit;

   typedef struct {
      logic        rst;
      logic        halt;
      logic        redir;
      logic [31:0] redirPc;
      logic        ready;
      logic        expReq;
      int          expAddr;
      logic        expValid;
      logic [31:0] expPc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        halt = 1'b0;
   logic        redirValid = 1'b0;
   logic [31:0] redirPc = '0;
   logic        imemReq;
   logic [9:0]  imemAddr;
   logic [31:0] imemRdata = '0;
   logic        outValid;
   logic        outReady = 1'b1;
   logic [31:0] outIr;
   logic [31:0] outPc;
   logic [31:0] outNpc;
   logic        outPred;

   logic [31:0] mem [1024];
   vec_t        vecs [$];
   int          vecCount = 0;
   int          miscompares = 0;

   rv_fetch_unit #(
      .XLEN       (32),
      .IMEM_DEPTH (1024),
      .FQ_DEPTH   (4),
      .RESET_PC   (32'h0)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .halt_i           (halt),
      .redirect_valid_i (redirValid),
      .redirect_pc_i    (redirPc),
      .imem_req_o       (imemReq),
      .imem_addr_o      (imemAddr),
      .imem_rdata_i     (imemRdata),
      .out_valid_o      (outValid),
      .out_ready_i      (outReady),
      .out_ir_o         (outIr),
      .out_pc_o         (outPc),
      .out_npc_o        (outNpc),
      .out_pred_taken_o (outPred)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Synchronous instruction memory: data appears the cycle after a request.
   always @(posedge clk) begin
      if (imemReq) begin
         imemRdata <= mem[imemAddr];
      end
   end

   function automatic void addVec(input logic r, input logic h, input logic d,
                                  input logic [31:0] rp, input logic rdy,
                                  input logic req, input int addr,
                                  input logic v, input logic [31:0] pc);
      vec_t t;
      t.rst = r; t.halt = h; t.redir = d; t.redirPc = rp; t.ready = rdy;
      t.expReq = req; t.expAddr = addr; t.expValid = v; t.expPc = pc;
      vecs.push_back(t);
   endfunction

   task automatic checkOutput(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s (step %0d): got %h, want %h", name, idx, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst        = v.rst;
      halt       = v.halt;
      redirValid = v.redir;
      redirPc    = v.redirPc;
      outReady   = v.ready;
   endtask

   task automatic checkVector(input vec_t v, input int idx);
      vecCount++;
      if (v.rst) begin
         checkOutput("rst_req", idx, 32'(imemReq), 32'h0);
         checkOutput("rst_valid", idx, 32'(outValid), 32'h0);
         checkOutput("rst_ir", idx, outIr, 32'h0);
         checkOutput("rst_pc", idx, outPc, 32'h0);
         checkOutput("rst_npc", idx, outNpc, 32'h0);
         checkOutput("rst_pred", idx, 32'(outPred), 32'h0);
      end else begin
         checkOutput("req", idx, 32'(imemReq), 32'(v.expReq));
         if (v.expReq) begin
            checkOutput("addr", idx, 32'(imemAddr), 32'(v.expAddr));
         end
         checkOutput("valid", idx, 32'(outValid), 32'(v.expValid));
         if (v.expValid) begin
            checkOutput("pc", idx, outPc, v.expPc);
            checkOutput("npc", idx, outNpc, v.expPc + 32'd4);
            checkOutput("ir", idx, outIr, mem[v.expPc[11:2]]);
            checkOutput("pred", idx, 32'(outPred), 32'h0);
         end
      end
   endtask

   // Reset, then stream until a branch at 0x10 appears; check its prediction
   // flag and the PC of the instruction that follows it.
   task automatic runBranch(input logic [31:0] word, input logic [31:0] expNext,
                            input logic expPred);
      logic seenBr;
      logic done;
      mem[4]     = word;
      rst        = 1'b1;
      halt       = 1'b0;
      redirValid = 1'b0;
      outReady   = 1'b1;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      seenBr = 1'b0;
      done   = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(posedge clk);
         #2;
         if (outValid) begin
            if (!seenBr) begin
               if (outPc == 32'h10) begin
                  seenBr = 1'b1;
                  vecCount++;
                  checkOutput("br_pred", cyc, 32'(outPred), 32'(expPred));
                  checkOutput("br_ir", cyc, outIr, word);
               end
            end else begin
               done = 1'b1;
               vecCount++;
               checkOutput("br_next_pc", cyc, outPc, expNext);
               checkOutput("br_next_ir", cyc, outIr, mem[expNext[11:2]]);
               checkOutput("br_next_pred", cyc, 32'(outPred), 32'h0);
            end
         end
      end
      if (!done) begin
         vecCount++;
         miscompares++;
         $display("[TB] FAIL br_timeout: got seen=%0d done=%0d, want done=1", seenBr, done);
      end
      mem[4] = 32'h0000_0013 | (32'd4 << 20);
   endtask

   initial begin
      for (int k = 0; k < 1024; k++) begin
         mem[k] = 32'h0000_0013 | (32'(k) << 20);
      end

      // Stream from reset with decode always ready.
      addVec(0,0,0,0,1, 1,0, 0,0);
      addVec(0,0,0,0,1, 1,1, 0,0);
      addVec(0,0,0,0,1, 1,2, 1,32'h00);
      addVec(0,0,0,0,1, 1,3, 1,32'h04);
      addVec(0,0,0,0,1, 1,4, 1,32'h08);
      addVec(0,0,0,0,1, 1,5, 1,32'h0c);
      // Decode stalls: queue fills to four and requests stop.
      addVec(0,0,0,0,0, 1,6, 1,32'h10);
      addVec(0,0,0,0,0, 1,7, 1,32'h10);
      addVec(0,0,0,0,0, 0,0, 1,32'h10);
      addVec(0,0,0,0,0, 0,0, 1,32'h10);
      // Drain: first pop at full gives no credit that cycle.
      addVec(0,0,0,0,1, 0,0, 1,32'h10);
      addVec(0,0,0,0,1, 1,8, 1,32'h14);
      addVec(0,0,0,0,1, 1,9, 1,32'h18);
      addVec(0,0,0,0,1, 1,10, 1,32'h1c);
      addVec(0,0,0,0,1, 1,11, 1,32'h20);
      // Refill, then redirect to 0x40 while full.
      addVec(0,0,0,0,0, 1,12, 1,32'h24);
      addVec(0,0,0,0,0, 0,0, 1,32'h24);
      addVec(0,0,1,32'h40,0, 0,0, 1,32'h24);
      addVec(0,0,0,0,1, 1,16, 0,0);
      addVec(0,0,0,0,1, 1,17, 0,0);
      addVec(0,0,0,0,1, 1,18, 1,32'h40);
      addVec(0,0,0,0,1, 1,19, 1,32'h44);
      // Misaligned redirect target is forced to a word boundary.
      addVec(0,0,1,32'h43,1, 0,0, 1,32'h48);
      addVec(0,0,0,0,1, 1,16, 0,0);
      addVec(0,0,0,0,1, 1,17, 0,0);
      addVec(0,0,0,0,1, 1,18, 1,32'h40);
      // Reset pulse mid-stream, then restart from 0.
      addVec(1,0,0,0,1, 0,0, 0,0);
      addVec(0,0,0,0,1, 1,0, 0,0);
      addVec(0,0,0,0,1, 1,1, 0,0);
      addVec(0,0,0,0,1, 1,2, 1,32'h00);
      // Halt with one read in flight: one more push, no new requests.
      addVec(0,1,0,0,0, 0,0, 1,32'h04);
      addVec(0,1,0,0,0, 0,0, 1,32'h04);
      addVec(0,1,0,0,1, 0,0, 1,32'h04);
      addVec(0,1,0,0,1, 0,0, 1,32'h08);
      addVec(0,1,0,0,1, 0,0, 0,0);
      // Redirect still lands while halted.
      addVec(0,1,1,32'h100,1, 0,0, 0,0);
      addVec(0,0,0,0,1, 1,64, 0,0);
      addVec(0,0,0,0,1, 1,65, 0,0);
      addVec(0,0,0,0,1, 1,66, 1,32'h100);
      addVec(0,0,0,0,1, 1,67, 1,32'h104);

      $display("[TB] starting, %0d table vectors", vecs.size());

      repeat (2) @(posedge clk);
      #2;
      vecCount++;
      checkOutput("init_req", -1, 32'(imemReq), 32'h0);
      checkOutput("init_valid", -1, 32'(outValid), 32'h0);
      checkOutput("init_pc", -1, outPc, 32'h0);
      checkOutput("init_ir", -1, outIr, 32'h0);
      checkOutput("init_npc", -1, outNpc, 32'h0);
      checkOutput("init_pred", -1, 32'(outPred), 32'h0);
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkVector(vecs[i], i);
         @(posedge clk);
         #1;
      end

`ifdef FETCH_BTFN_EN
      // beq x0,x0,-8 at 0x10 is predicted taken back to 0x08.
      runBranch(32'hFE00_0CE3, 32'h08, 1'b1);
`else
      // Without prediction the backward branch falls through.
      runBranch(32'hFE00_0CE3, 32'h14, 1'b0);
`endif
      // Forward branch (beq x0,x0,+8) is never predicted taken.
      runBranch(32'h0000_0463, 32'h14, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, miscompares);
      $finish;
   end

endmodule
